// File: rtl/spi_tx_sequencer_pkg.sv
// Shared types for the SPI transmit sequencer: byte payload and sequencer FSM states.
package spi_tx_sequencer_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] spi_byte_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESENT = 3'd1,
        ACTIVE  = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4,
        ABORT   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// Write port and spi_controller-facing handshake of the transmit sequencer.
interface spi_tx_sequencer_if;
    import spi_tx_sequencer_pkg::*;

    logic      wrValidIn;
    logic      wrReadyOut;
    spi_byte_t wrDataIn;
    logic      tValidOut;
    spi_byte_t tDataOut;
    logic      tReadyIn;
    logic      ssIn;

    modport master (
        output wrValidIn, wrDataIn, tReadyIn, ssIn,
        input  wrReadyOut, tValidOut, tDataOut
    );

    modport slave (
        input  wrValidIn, wrDataIn, tReadyIn, ssIn,
        output wrReadyOut, tValidOut, tDataOut
    );

endinterface

// File: rtl/spi_seq_fifo.sv
// Byte FIFO with registered level/full/empty; pointers wrap naturally, level is one bit wider.
module spi_seq_fifo
    import spi_tx_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   sysClkIn,
    input  logic                   sysRstIn,
    input  logic                   push,
    input  logic                   pop,
    input  spi_byte_t              wrData,
    output spi_byte_t              headData_c,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] levelNext_c,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    spi_byte_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_comb begin
        levelNext_c = level;
        if (doPush && !doPop) begin
            levelNext_c = level + LVL_W'(1);
        end else if (!doPush && doPop) begin
            levelNext_c = level - LVL_W'(1);
        end
    end

    always_ff @(posedge sysClkIn or posedge sysRstIn) begin
        if (sysRstIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            level <= levelNext_c;
            full  <= (levelNext_c == LVL_W'(DEPTH));
            empty <= (levelNext_c == '0);
        end
    end

    always_ff @(posedge sysClkIn) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    assign headData_c = mem[rdPtr];

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds buffered bytes one at a time to spi_controller, popping each after its SS low->high window.
// Optional inter-byte idle gap is built when SPI_SEQ_GAP_EN is defined.
module spi_tx_sequencer
    import spi_tx_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned SS_TIMEOUT = 64
) (
    input  logic                        sysClkIn,
    input  logic                        sysRstIn,
    spi_tx_sequencer_if.slave           seqIf,
    output logic                        busyOut,
    output logic [$clog2(FIFO_DEPTH):0] levelOut,
    output logic                        timeoutOut
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TO_W  = (SS_TIMEOUT > 1) ? $clog2(SS_TIMEOUT) : 1;

    seq_state_e       state;
    seq_state_e       stateNext;
    logic [TO_W-1:0]  toCnt;
    logic [TO_W-1:0]  toCntNext;
    logic             toExpired;
    logic             gapDone;
    logic             pushC;
    logic             popC;
    logic             loadData;
    logic             tValidNext;
    logic             timeoutNext;
    logic             busyNext;
    spi_byte_t        headData;
    logic [LVL_W-1:0] fifoLevelNext;
    logic             fifoFull;
    logic             fifoEmpty;

    assign pushC = seqIf.wrValidIn && !fifoFull;
    assign popC  = (state == RELEASE);

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .sysClkIn    (sysClkIn),
        .sysRstIn    (sysRstIn),
        .push        (pushC),
        .pop         (popC),
        .wrData      (seqIf.wrDataIn),
        .headData_c  (headData),
        .level       (levelOut),
        .levelNext_c (fifoLevelNext),
        .full        (fifoFull),
        .empty       (fifoEmpty)
    );

    assign seqIf.wrReadyOut = !fifoFull;
    assign toExpired        = (toCnt == TO_W'(SS_TIMEOUT - 1));

`ifdef SPI_SEQ_GAP_EN
    // GAP plus the IDLE cycle that follows it together make GAP_CYCLES idle cycles.
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;

    logic [GAP_W-1:0] gapCnt;

    assign gapDone = (gapCnt == GAP_W'(GAP_LAST));

    always_ff @(posedge sysClkIn or posedge sysRstIn) begin
        if (sysRstIn) begin
            gapCnt <= '0;
        end else if (state == GAP && !gapDone) begin
            gapCnt <= gapCnt + GAP_W'(1);
        end else begin
            gapCnt <= '0;
        end
    end
`else
    assign gapDone = 1'b1;

    // GAP_CYCLES only sizes the gap counter, which this build leaves out.
    if (GAP_CYCLES == 0) begin : gNoGapCycles
    end
`endif

    always_ff @(posedge sysClkIn or posedge sysRstIn) begin
        if (sysRstIn) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (!fifoEmpty && seqIf.tReadyIn) stateNext = PRESENT;
            PRESENT: begin
                if (!seqIf.ssIn)    stateNext = ACTIVE;
                else if (toExpired) stateNext = ABORT;
            end
            ACTIVE:  if (seqIf.ssIn) stateNext = RELEASE;
`ifdef SPI_SEQ_GAP_EN
            RELEASE: stateNext = GAP;
`else
            RELEASE: stateNext = IDLE;
`endif
            GAP:     if (gapDone) stateNext = IDLE;
            ABORT:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        tValidNext  = 1'b0;
        timeoutNext = 1'b0;
        loadData    = 1'b0;
        toCntNext   = '0;
        tValidNext  = (stateNext == PRESENT) || (stateNext == ACTIVE);
        timeoutNext = (stateNext == ABORT);
        loadData    = (state == IDLE) && (stateNext == PRESENT);
        if (state == PRESENT && stateNext == PRESENT) begin
            toCntNext = toCnt + TO_W'(1);
        end
        busyNext    = (fifoLevelNext != '0) || (stateNext != IDLE);
    end

    always_ff @(posedge sysClkIn or posedge sysRstIn) begin
        if (sysRstIn) begin
            seqIf.tValidOut <= 1'b0;
            seqIf.tDataOut  <= '0;
            timeoutOut      <= 1'b0;
            busyOut         <= 1'b0;
            toCnt           <= '0;
        end else begin
            seqIf.tValidOut <= tValidNext;
            if (loadData) seqIf.tDataOut <= headData;
            timeoutOut      <= timeoutNext;
            busyOut         <= busyNext;
            toCnt           <= toCntNext;
        end
    end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed + randomized bench for spi_tx_sequencer with a queue-based byte model and SS-driving controller model.
module tb_spi_tx_sequencer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 64;
`ifdef SPI_SEQ_GAP_EN
    localparam int unsigned IDLE_BETWEEN = 4;
`else
    localparam int unsigned IDLE_BETWEEN = 1;
`endif

    logic       sysClkIn;
    logic       sysRstIn;
    logic       busyOut;
    logic [4:0] levelOut;
    logic       timeoutOut;

    int nChecks;
    int nFails;
    logic [7:0] model[$];

    spi_tx_sequencer_if seqIf ();

    spi_tx_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (4),
        .SS_TIMEOUT (TIMEOUT)
    ) dut (
        .sysClkIn   (sysClkIn),
        .sysRstIn   (sysRstIn),
        .seqIf      (seqIf),
        .busyOut    (busyOut),
        .levelOut   (levelOut),
        .timeoutOut (timeoutOut)
    );

    initial sysClkIn = 1'b0;
    always #5 sysClkIn = ~sysClkIn;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClkIn);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bit accept;
        accept = (model.size() < DEPTH);
        check("wrReadyOut before write", 32'(seqIf.wrReadyOut), 32'(accept));
        seqIf.wrValidIn = 1'b1;
        seqIf.wrDataIn  = b;
        tick();
        seqIf.wrValidIn = 1'b0;
        if (accept) model.push_back(b);
        check("levelOut after write", 32'(levelOut), 32'(model.size()));
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (seqIf.tValidOut !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (n < 200);
        check("tValidOut rise within budget", 32'(ok), 32'd1);
    endtask

    // Controller model: drops SS, shifts the byte MSB first, raises SS, then checks pop timing.
    task automatic serve(input bit pushInRel, input logic [7:0] relByte);
        bit         ok;
        int         z;
        logic [7:0] cap;
        wait_valid(ok);
        if (!ok) return;
        check("tDataOut is FIFO head", 32'(seqIf.tDataOut), 32'(model[0]));
        repeat ($urandom_range(3, 0)) tick();
        seqIf.ssIn = 1'b0;
        cap = '0;
        for (int i = 7; i >= 0; i--) begin
            tick();
            check("tValidOut held while SS low", 32'(seqIf.tValidOut), 32'd1);
            cap = {cap[6:0], seqIf.tDataOut[i]};
        end
        check("MOSI byte", 32'(cap), 32'(model[0]));
        seqIf.ssIn = 1'b1;
        tick();
        check("tValidOut low after SS rise", 32'(seqIf.tValidOut), 32'd0);
        check("levelOut before pop", 32'(levelOut), 32'(model.size()));
        if (pushInRel) begin
            seqIf.wrValidIn = 1'b1;
            seqIf.wrDataIn  = relByte;
        end
        tick();
        seqIf.wrValidIn = 1'b0;
        void'(model.pop_front());
        if (pushInRel) model.push_back(relByte);
        check("levelOut after pop", 32'(levelOut), 32'(model.size()));
        check("busyOut after pop", 32'(busyOut), 32'(model.size() != 0));
        if (model.size() != 0 && seqIf.tReadyIn) begin
            z = 1;
            tick();
            while (seqIf.tValidOut !== 1'b1 && z < 20) begin
                z++;
                tick();
            end
            check("idle cycles between bytes", 32'(z), 32'(IDLE_BETWEEN));
        end
    endtask

    initial begin
        bit ok;
        int cnt;
        nChecks = 0;
        nFails  = 0;
        sysRstIn        = 1'b1;
        seqIf.wrValidIn = 1'b0;
        seqIf.wrDataIn  = '0;
        seqIf.tReadyIn  = 1'b1;
        seqIf.ssIn      = 1'b1;
        #3;
        check("reset tValidOut", 32'(seqIf.tValidOut), 32'd0);
        check("reset tDataOut", 32'(seqIf.tDataOut), 32'd0);
        check("reset wrReadyOut", 32'(seqIf.wrReadyOut), 32'd1);
        check("reset busyOut", 32'(busyOut), 32'd0);
        check("reset levelOut", 32'(levelOut), 32'd0);
        check("reset timeoutOut", 32'(timeoutOut), 32'd0);
        tick();
        tick();
        sysRstIn = 1'b0;
        tick();

        // Controller not ready: byte waits in the FIFO.
        seqIf.tReadyIn = 1'b0;
        write_byte(8'h81);
        repeat (5) begin
            tick();
            check("no present while tReadyIn low", 32'(seqIf.tValidOut), 32'd0);
        end
        check("busyOut with queued byte", 32'(busyOut), 32'd1);
        seqIf.tReadyIn = 1'b1;
        serve(1'b0, 8'h00);

        // Two bytes, two SS windows.
        write_byte(8'hA5);
        write_byte(8'h3C);
        serve(1'b0, 8'h00);
        serve(1'b0, 8'h00);

        // SS never goes low: abort after the timeout, head kept and retried.
        write_byte(8'h5A);
        wait_valid(ok);
        cnt = 0;
        while (timeoutOut !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("timeout latency from tValidOut rise", 32'(cnt), 32'(TIMEOUT));
        check("tValidOut low on abort", 32'(seqIf.tValidOut), 32'd0);
        check("levelOut kept on abort", 32'(levelOut), 32'd1);
        tick();
        check("timeoutOut single pulse", 32'(timeoutOut), 32'd0);
        serve(1'b0, 8'h00);

        // Push lands in the pop cycle at level 1.
        write_byte(8'hC3);
        serve(1'b1, 8'h7E);
        serve(1'b0, 8'h00);

        // Overfill with SS held high: the 17th byte is dropped.
        for (int i = 0; i < DEPTH + 1; i++) write_byte(8'($urandom));
        check("wrReadyOut when full", 32'(seqIf.wrReadyOut), 32'd0);
        check("levelOut when full", 32'(levelOut), 32'(DEPTH));
        while (model.size() != 0) serve(1'b0, 8'h00);

        // Async reset while a byte is in flight with more queued.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_valid(ok);
        seqIf.ssIn = 1'b0;
        tick();
        tick();
        check("tValidOut during active byte", 32'(seqIf.tValidOut), 32'd1);
        #2 sysRstIn = 1'b1;
        #1;
        check("mid-active reset tValidOut", 32'(seqIf.tValidOut), 32'd0);
        check("mid-active reset levelOut", 32'(levelOut), 32'd0);
        check("mid-active reset wrReadyOut", 32'(seqIf.wrReadyOut), 32'd1);
        check("mid-active reset busyOut", 32'(busyOut), 32'd0);
        model.delete();
        tick();
        sysRstIn   = 1'b0;
        seqIf.ssIn = 1'b1;
        tick();

        // Random bursts with random controller timing.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++) write_byte(8'($urandom));
            while (model.size() != 0) serve(1'b0, 8'h00);
        end

        tick();
        tick();
        check("final busyOut", 32'(busyOut), 32'd0);
        check("final levelOut", 32'(levelOut), 32'd0);
        check("final tValidOut", 32'(seqIf.tValidOut), 32'd0);
        check("final wrReadyOut", 32'(seqIf.wrReadyOut), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
